// File: rtl/exu_pkg.sv
// Shared definitions for the EXU issue/sequencing controller.
//   - EXU unit select codes, MDU/FPU op codes that affect latency
//   - controller state encoding
//   - lat_sel: fixed latency of a multi-cycle op
//   - maxLat:  largest of the four latencies (sizes the latency counter)
package exu_pkg;

    localparam logic [1:0] EXU_ALU = 2'b00;
    localparam logic [1:0] EXU_MDU = 2'b01;
    localparam logic [1:0] EXU_FPU = 2'b10;

    localparam logic       MDU_MUL = 1'b0;
    localparam logic       MDU_DIV = 1'b1;

    localparam logic [2:0] FPU_DIV  = 3'b011;
    localparam logic [2:0] FPU_SQRT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_WB     = 2'd2,
        ST_HALTED = 2'd3
    } exuState_t;

    // Latency of a multi-cycle op; ALU codes return 1 but are never loaded.
    function automatic int lat_sel(input logic [1:0] exuOp, input logic mduOp,
                                   input logic [2:0] fpuOp, input int mulLat,
                                   input int divLat, input int fpuLat, input int fdivLat);
        int lat;
        lat = 1;
        if (exuOp == EXU_MDU) begin
            lat = (mduOp == MDU_DIV) ? divLat : mulLat;
        end else if (exuOp == EXU_FPU) begin
            lat = (fpuOp == FPU_DIV || fpuOp == FPU_SQRT) ? fdivLat : fpuLat;
        end
        return lat;
    endfunction

    function automatic int maxLat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/exu_lat_counter.sv
// Loadable down-counter used to time a pending multi-cycle op.
// Ports:
//   iClk, iRst   clock, synchronous active-high reset (count -> 0)
//   iLoad        load iLoadVal (has priority over decrement)
//   iLoadVal     value to load
//   iDec         decrement request; ignored once the count is zero
//   oCnt         current count
//   oZero        count is zero
module exu_lat_counter #(
    parameter int W = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iLoad,
    input  logic [W-1:0] iLoadVal,
    input  logic         iDec,
    output logic [W-1:0] oCnt,
    output logic         oZero
);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCnt <= '0;
        end else if (iLoad) begin
            oCnt <= iLoadVal;
        end else if (iDec && (oCnt != '0)) begin
            oCnt <= oCnt - W'(1);
        end
    end

    assign oZero = (oCnt == '0);

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue/sequencing controller between the decoder and the EXU.
// Starts multi-cycle MDU/FPU ops, times their fixed latency, owns the
// regfile write port in the completion cycle, stalls decode on hazards
// against the single pending destination and on port conflicts, and
// handles HALT (drain pending op, then freeze until reset).
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iValid                     decoded instruction present
//   iExuOp, iMduOp, iFpuOp     unit select and op codes
//   iHalt                      instruction is HALT
//   iEnRead0/1, iAddrRead0/1   source operands
//   iEnWrite, iAddrWrite       destination
//   oIssue, oStall             accept / hold decode (combinational)
//   oMduStart, oFpuStart       start pulses (combinational)
//   oWbSel, oWbEn, oWbAddr     multi-cycle writeback control (registered)
//   oBusy                      multi-cycle op pending
//   oHalted                    halt reached (registered)
module exu_issue_ctrl
    import exu_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 16,
    parameter int FPU_LAT  = 4,
    parameter int FDIV_LAT = 12
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iValid,
    input  logic [1:0] iExuOp,
    input  logic       iMduOp,
    input  logic [2:0] iFpuOp,
    input  logic       iHalt,
    input  logic       iEnRead0,
    input  logic [4:0] iAddrRead0,
    input  logic       iEnRead1,
    input  logic [4:0] iAddrRead1,
    input  logic       iEnWrite,
    input  logic [4:0] iAddrWrite,
    output logic       oIssue,
    output logic       oStall,
    output logic       oMduStart,
    output logic       oFpuStart,
    output logic       oWbSel,
    output logic       oWbEn,
    output logic [4:0] oWbAddr,
    output logic       oBusy,
    output logic       oHalted
);

    localparam int MAX_LAT = maxLat(MUL_LAT, DIV_LAT, FPU_LAT, FDIV_LAT);
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    exuState_t  state, stateNext;
    logic [4:0] pendDst;
    logic       pendEn;
    logic       pendValid;
    logic       isMdu, isFpu, isMulti, isAlu;
    logic       hazard, stallCause, issue, loadCnt;
    logic [CNT_W-1:0] cnt, cntLoadVal;
    logic       cntZero;
    int         latNow;

    // HALT takes precedence over whatever unit code accompanies it.
    assign isMdu   = ~iHalt & (iExuOp == EXU_MDU);
    assign isFpu   = ~iHalt & (iExuOp == EXU_FPU);
    assign isMulti = isMdu | isFpu;
    assign isAlu   = ~iHalt & ~isMulti;

    assign pendValid = (state == ST_BUSY) || (state == ST_WB);

    assign hazard = pendValid & pendEn &
                    ((iEnRead0 & (iAddrRead0 == pendDst)) |
                     (iEnRead1 & (iAddrRead1 == pendDst)) |
                     (iEnWrite & (iAddrWrite == pendDst)));

    // The WB cycle owns the regfile write port, so a writing ALU op must wait.
    assign stallCause = hazard
                      | (isMulti & (state == ST_BUSY))
                      | (isAlu & iEnWrite & (state == ST_WB))
                      | (iHalt & pendValid)
                      | (state == ST_HALTED);

    assign issue     = iValid & ~stallCause & ~iRst;
    assign oIssue    = issue;
    assign oStall    = ~iRst & ((iValid & ~issue) | oHalted);
    assign oMduStart = issue & isMdu;
    assign oFpuStart = issue & isFpu;
    assign oBusy     = pendValid;

    assign loadCnt = issue & isMulti;

    // Counter holds L-2 at the first BUSY cycle so WB lands exactly L cycles after start.
    assign latNow     = lat_sel(iExuOp, iMduOp, iFpuOp, MUL_LAT, DIV_LAT, FPU_LAT, FDIV_LAT);
    assign cntLoadVal = CNT_W'(latNow - 2);

    exu_lat_counter #(.W(CNT_W)) uLatCounter (
        .iClk     (iClk),
        .iRst     (iRst),
        .iLoad    (loadCnt),
        .iLoadVal (cntLoadVal),
        .iDec     (state == ST_BUSY),
        .oCnt     (cnt),
        .oZero    (cntZero)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE, ST_WB: begin
                if (loadCnt) begin
                    stateNext = ST_BUSY;
                end else if (issue & iHalt) begin
                    stateNext = ST_HALTED;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cntZero) stateNext = ST_WB;
            end
            ST_HALTED: stateNext = ST_HALTED;
            default:   stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            pendDst <= '0;
            pendEn  <= 1'b0;
            oWbSel  <= 1'b0;
            oWbEn   <= 1'b0;
            oWbAddr <= '0;
            oHalted <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadCnt) begin
                pendDst <= iAddrWrite;
                pendEn  <= iEnWrite;
            end
            // Writeback controls are registered so they are valid for the whole WB cycle.
            oWbSel  <= (stateNext == ST_WB);
            oWbEn   <= (stateNext == ST_WB) & pendEn;
            oWbAddr <= (stateNext == ST_WB) ? pendDst : 5'd0;
            oHalted <= (stateNext == ST_HALTED);
        end
    end

endmodule
